// File: rtl/noc_router_xy_if.sv
// Bundled flit ports of one 5-port mesh router node.
// The master side is the surrounding mesh and the slave side is the router.
interface noc_router_xy_if #(
  parameter int FLIT_W = 24
);
  logic [5*FLIT_W-1:0] i_data;
  logic [4:0]          i_valid;
  logic [4:0]          o_ready;
  logic [5*FLIT_W-1:0] o_data;
  logic [4:0]          o_valid;
  logic [4:0]          i_ready;

  modport master (output i_data, i_valid, i_ready, input o_ready, o_data, o_valid);
  modport slave  (input i_data, i_valid, i_ready, output o_ready, o_data, o_valid);
endinterface

// File: rtl/noc_router_xy.sv
// Five-port mesh router node: per-input FIFOs, X-then-Y routing on the FIFO heads,
// and a round-robin arbiter feeding a registered valid/ready stage on each output.
module noc_router_xy #(
  parameter int FLIT_W   = 24,
  parameter int COORD_W  = 8,
  parameter int DEPTH    = 4,
  parameter int ROUTER_X = 4,
  parameter int ROUTER_Y = 4
) (
  input  logic            clk,
  input  logic            rstn,
  noc_router_xy_if.slave  bus
);
  localparam int NP = 5;
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] P_PE = 3'd0, P_T = 3'd1, P_R = 3'd2, P_B = 3'd3, P_L = 3'd4;

  function automatic logic [2:0] route(input logic [FLIT_W-1:0] flit);
    logic [COORD_W-1:0] dx, dy;
    dx = flit[2*COORD_W-1:COORD_W];
    dy = flit[COORD_W-1:0];
    if (dx > COORD_W'(ROUTER_X))      return P_R;
    else if (dx < COORD_W'(ROUTER_X)) return P_L;
    else if (dy > COORD_W'(ROUTER_Y)) return P_T;
    else if (dy < COORD_W'(ROUTER_Y)) return P_B;
    else                              return P_PE;
  endfunction

  // Returns {found, index} of the first set request at or after ptr, mod 5.
  function automatic logic [3:0] rr_pick(input logic [NP-1:0] req, input logic [2:0] ptr);
    logic [3:0] res;
    logic [3:0] s;
    res = 4'b0;
    for (int k = NP - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + 4'(k);
      if (s >= 4'(NP)) s = s - 4'(NP);
      if (req[s[2:0]]) res = {1'b1, s[2:0]};
    end
    return res;
  endfunction

  logic [FLIT_W-1:0]   mem      [NP][DEPTH];
  logic [AW:0]         wptr     [NP];
  logic [AW:0]         rptr     [NP];
  logic [AW:0]         wptr_nxt [NP];
  logic [AW:0]         rptr_nxt [NP];
  logic [FLIT_W-1:0]   head     [NP];
  logic [2:0]          dst      [NP];
  logic [NP-1:0]       req      [NP];
  logic [2:0]          rr_ptr   [NP];
  logic [2:0]          gnt_idx  [NP];
  logic [3:0]          pick     [NP];
  logic [NP-1:0]       empty, full_nxt, push, pop, gnt_vld;
  logic [NP-1:0]       o_valid_q, o_ready_q;
  logic [NP*FLIT_W-1:0] o_data_q;

  assign bus.o_valid = o_valid_q;
  assign bus.o_ready = o_ready_q;
  assign bus.o_data  = o_data_q;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      empty[p] = (wptr[p] == rptr[p]);
      head[p]  = mem[p][rptr[p][AW-1:0]];
      dst[p]   = route(head[p]);
      push[p]  = bus.i_valid[p] & o_ready_q[p];
    end
  end

  // Each head requests exactly one output, so an input can never win twice in a cycle.
  always_comb begin
    pop = '0;
    for (int q = 0; q < NP; q++) begin
      for (int p = 0; p < NP; p++) req[q][p] = !empty[p] && (dst[p] == 3'(q));
      pick[q]    = rr_pick(req[q], rr_ptr[q]);
      gnt_vld[q] = pick[q][3] & (!o_valid_q[q] | bus.i_ready[q]);
      gnt_idx[q] = pick[q][2:0];
      for (int p = 0; p < NP; p++)
        if (gnt_vld[q] && gnt_idx[q] == 3'(p)) pop[p] = 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      wptr_nxt[p] = wptr[p] + {{AW{1'b0}}, push[p]};
      rptr_nxt[p] = rptr[p] + {{AW{1'b0}}, pop[p]};
      full_nxt[p] = (wptr_nxt[p][AW] != rptr_nxt[p][AW]) &&
                    (wptr_nxt[p][AW-1:0] == rptr_nxt[p][AW-1:0]);
    end
  end

  // Ready is registered from the post-update occupancy, so a pop frees a slot next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < NP; p++) begin
        wptr[p]   <= '0;
        rptr[p]   <= '0;
        rr_ptr[p] <= '0;
      end
      o_valid_q <= '0;
      o_ready_q <= '0;
      o_data_q  <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        wptr[p]      <= wptr_nxt[p];
        rptr[p]      <= rptr_nxt[p];
        o_ready_q[p] <= !full_nxt[p];
      end
      for (int q = 0; q < NP; q++) begin
        if (gnt_vld[q]) begin
          o_data_q[q*FLIT_W +: FLIT_W] <= head[gnt_idx[q]];
          o_valid_q[q]                 <= 1'b1;
          rr_ptr[q]                    <= (gnt_idx[q] == 3'd4) ? 3'd0 : gnt_idx[q] + 3'd1;
        end else if (bus.i_ready[q]) begin
          o_valid_q[q] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (push[p]) mem[p][wptr[p][AW-1:0]] <= bus.i_data[p*FLIT_W +: FLIT_W];
  end

endmodule

// File: tb/tb_noc_router_xy.sv
// Self-checking bench for noc_router_xy at node (4,4): routing table, backpressure,
// contention, FIFO full, mid-operation reset and parallel traffic, with a scoreboard.
module tb_noc_router_xy;
  localparam int FW = 24;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  noc_router_xy_if #(.FLIT_W(FW)) bus ();

  noc_router_xy #(.FLIT_W(FW), .COORD_W(8), .DEPTH(4), .ROUTER_X(4), .ROUTER_Y(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int          src;
    int          dst;
    logic [23:0] flit;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int          port;
    logic [23:0] flit;
    int          exp_port;
  } vec_t;

  function automatic int route_m(input logic [23:0] f);
    if (f[15:8] > 8'd4) return 2;
    if (f[15:8] < 8'd4) return 4;
    if (f[7:0] > 8'd4)  return 1;
    if (f[7:0] < 8'd4)  return 3;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard: pushes on accepted inputs, matches and order-checks each delivered flit.
  always @(negedge clk) begin
    logic [23:0] f;
    int idx;
    logic ordered;
    if (rstn) begin
      for (int q = 0; q < 5; q++) begin
        if (bus.o_valid[q] && bus.i_ready[q]) begin
          f = bus.o_data[q*FW +: FW];
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].dst == q && sb[i].flit == f) idx = i;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: port %0d got %h, required no delivery", q, f);
          end else begin
            ordered = 1'b1;
            for (int i = 0; i < idx; i++)
              if (sb[i].dst == q && sb[i].src == sb[idx].src) ordered = 1'b0;
            chk("sb_order", 32'(ordered), 32'd1);
            sb.delete(idx);
          end
        end
      end
      for (int p = 0; p < 5; p++) begin
        if (bus.i_valid[p] && bus.o_ready[p]) begin
          f = bus.i_data[p*FW +: FW];
          sb.push_back('{src: p, dst: route_m(f), flit: f});
        end
      end
    end
  end

  task automatic do_reset();
    bus.i_valid = '0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || bus.o_valid != 5'd0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic send_route(input int port, input logic [23:0] flit, input int exp_port);
    bus.i_data[port*FW +: FW] = flit;
    bus.i_valid = 5'(1 << port);
    @(posedge clk); #1;
    bus.i_valid = '0;
    @(negedge clk);
    chk("route_early", 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    chk("route_valid", 32'(bus.o_valid), 32'(1 << exp_port));
    chk("route_data", 32'(bus.o_data[exp_port*FW +: FW]), 32'(flit));
    @(negedge clk);
    chk("route_clear", 32'(bus.o_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   exp_src[3];
    int   seq[5];
    int   n, k;
    logic [4:0] acc;

    vecs[0] = '{1, 24'hAA0304, 4};
    vecs[1] = '{1, 24'hAA0404, 0};
    vecs[2] = '{1, 24'hAA0403, 3};
    vecs[3] = '{1, 24'hAA0503, 2};
    vecs[4] = '{1, 24'hAA0405, 1};
    vecs[5] = '{2, 24'hBB0204, 4};
    vecs[6] = '{0, 24'hCC0404, 0};
    vecs[7] = '{4, 24'hDD0406, 1};
    exp_src[0] = 0; exp_src[1] = 2; exp_src[2] = 3;

    bus.i_data  = '0;
    bus.i_valid = '0;
    bus.i_ready = 5'h1f;

    // Reset state and release timing
    @(negedge clk);
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_o_data", 32'(bus.o_data[23:0] | bus.o_data[119:96]), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("release_ready_before_edge", 32'(bus.o_ready), 32'd0);
    @(negedge clk);
    chk("release_ready", 32'(bus.o_ready), 32'h1f);
    @(posedge clk); #1;

    // Routing table
    for (int i = 0; i < 8; i++) send_route(vecs[i].port, vecs[i].flit, vecs[i].exp_port);
    drain("route_drain");

    // Backpressure on output l
    bus.i_ready = 5'b01111;
    bus.i_data[1*FW +: FW] = 24'h110304;
    bus.i_valid = 5'b00010;
    @(posedge clk); #1;
    bus.i_valid = '0;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.o_valid[4]), 32'd1);
      chk("bp_hold_data", 32'(bus.o_data[4*FW +: FW]), 32'h110304);
    end
    @(posedge clk); #1;
    bus.i_ready = 5'h1f;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_clear", 32'(bus.o_valid[4]), 32'd0);
    @(posedge clk); #1;
    drain("bp_drain");

    // Contention: pe, r and b all target l
    do_reset();
    seq = '{default: 0};
    for (int p = 0; p < 5; p++) bus.i_data[p*FW +: FW] = {4'(p), 4'd0, 16'h0304};
    bus.i_valid = 5'b01101;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      acc = bus.i_valid & bus.o_ready;
      if (bus.o_valid[4]) begin
        chk("contention_src", 32'(bus.o_data[4*FW+20 +: 4]), 32'(exp_src[k % 3]));
        k++;
      end
      @(posedge clk); #1;
      for (int p = 0; p < 5; p++)
        if (acc[p]) begin
          seq[p]++;
          bus.i_data[p*FW +: FW] = {4'(p), 4'(seq[p]), 16'h0304};
        end
    end
    bus.i_valid = '0;
    chk("contention_grants", 32'(k >= 24), 32'd1);
    drain("contention_drain");

    // FIFO full: output pe blocked, six flits t -> pe
    do_reset();
    bus.i_ready = 5'b11110;
    n = 0;
    bus.i_data[1*FW +: FW] = 24'h500404;
    bus.i_valid = 5'b00010;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      acc = bus.i_valid & bus.o_ready;
      @(posedge clk); #1;
      if (acc[1]) begin
        n++;
        bus.i_data[1*FW +: FW] = {8'h50 + 8'(n), 16'h0404};
      end
    end
    chk("full_accepts", 32'(n), 32'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full_ready_low", 32'(bus.o_ready[1]), 32'd0);
      chk("full_out_valid", 32'(bus.o_valid[0]), 32'd1);
      chk("full_out_data", 32'(bus.o_data[23:0]), 32'h500404);
    end
    @(posedge clk); #1;
    bus.i_ready = 5'h1f;
    @(negedge clk);
    chk("full_ready_before_pop", 32'(bus.o_ready[1]), 32'd0);
    @(negedge clk);
    chk("full_ready_after_pop", 32'(bus.o_ready[1]), 32'd1);
    @(posedge clk); #1;
    bus.i_valid = '0;
    drain("full_drain");

    // Reset mid-operation with flits buffered
    do_reset();
    bus.i_ready = 5'b11110;
    n = 0;
    bus.i_data[1*FW +: FW] = 24'h600404;
    bus.i_valid = 5'b00010;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      acc = bus.i_valid & bus.o_ready;
      @(posedge clk); #1;
      if (acc[1]) begin
        n++;
        bus.i_data[1*FW +: FW] = {8'h60 + 8'(n), 16'h0404};
      end
    end
    bus.i_valid = '0;
    @(posedge clk); #1;
    chk("midrst_pre_valid", 32'(bus.o_valid[0]), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.o_valid), 32'd0);
    chk("midrst_ready", 32'(bus.o_ready), 32'd0);
    chk("midrst_data", 32'(bus.o_data[23:0]), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    sb.delete();
    bus.i_ready = 5'h1f;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(bus.o_valid), 32'd0);
    end
    chk("midrst_ready_back", 32'(bus.o_ready), 32'h1f);
    @(posedge clk); #1;

    // Parallel traffic on five disjoint outputs
    do_reset();
    seq = '{default: 0};
    bus.i_data[0*FW +: FW] = {8'h00, 16'h0404};
    bus.i_data[1*FW +: FW] = {8'h10, 16'h0403};
    bus.i_data[2*FW +: FW] = {8'h20, 16'h0304};
    bus.i_data[3*FW +: FW] = {8'h30, 16'h0405};
    bus.i_data[4*FW +: FW] = {8'h40, 16'h0504};
    bus.i_valid = 5'h1f;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc = bus.i_valid & bus.o_ready;
      if (c >= 2) begin
        chk("par_all_valid", 32'(bus.o_valid), 32'h1f);
        chk("par_all_ready", 32'(bus.o_ready), 32'h1f);
      end
      @(posedge clk); #1;
      for (int p = 0; p < 5; p++)
        if (acc[p]) begin
          seq[p]++;
          bus.i_data[p*FW+16 +: 8] = {4'(p), 4'(seq[p])};
        end
    end
    bus.i_valid = '0;
    drain("par_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_router_xy.md
Name: noc_router_xy

Overview:
- Parametrised successor to the fixed 24-bit 5-port mesh switch: one router node with ports PE, top, right, bottom and left.
- Each input has its own FIFO buffer. Route selection uses dimension-ordered (X-then-Y) routing on destination coordinates carried in each flit.
- Each output has a round-robin arbiter and a registered valid/ready output stage.
- Packets are single-flit; one instance sits at each mesh node.

Parameters:
FLIT_W, 24, flit width in bits; must be ≥ 2*COORD_W.
COORD_W, 8, width of each destination coordinate field.
DEPTH, 4, entries per input FIFO; power of two, ≥ 2.
ROUTER_X, 4, this node's X coordinate.
ROUTER_Y, 4, this node's Y coordinate.

Ports:
clk  input  1  clock; all state updates on rising edge.
rstn  input  1  asynchronous active-low reset.
i_data  input  5*FLIT_W  inbound flits; slice p = [p*FLIT_W +: FLIT_W]; p: 0=pe 1=t 2=r 3=b 4=l.
i_valid  input  5  inbound flit valid, per port.
o_ready  output  5  inbound ready, per port.
o_data  output  5*FLIT_W  outbound flits, same slicing.
o_valid  output  5  outbound valid, per port.
i_ready  input  5  downstream ready, per port.

Behaviour:
- Interface: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset state (while rstn=0): all FIFOs empty, all RR pointers=0, o_valid=0, o_data=0, o_ready=0.
- Release: o_ready=1 from the first edge after rstn rises.
- Reset mid-operation: all buffered and in-flight flits are discarded, with no partial output.
- Flit fields: dest_x=flit[2*COORD_W-1:COORD_W], dest_y=flit[COORD_W-1:0]. Upper bits are payload and pass through unmodified.
- Input accept: on edge when i_valid[p] & o_ready[p], write the flit to FIFO p.
  - o_ready[p] = !full[p], registered.
  - A pop in the same cycle does not make a full FIFO accept; ready reasserts the cycle after the pop.
- FIFO: circular buffer with log2(DEPTH)+1-bit read/write pointers. full when MSBs differ and LSBs are equal. Wrap-around is mandatory.
- Routing, combinational on the FIFO head (unsigned compares):
  - dest_x > ROUTER_X → r
  - dest_x < ROUTER_X → l
  - otherwise dest_y > ROUTER_Y → t
  - otherwise dest_y < ROUTER_Y → b
  - otherwise → pe
  - U-turns are not filtered; a flit routed back out its own input port is delivered.
- Arbitration, per output q:
  - Requesters are non-empty inputs whose head routes to q.
  - The output stage may load when !o_valid[q] | i_ready[q].
  - Grant goes to the first requester at or after rr_ptr[q], searching upward mod 5.
  - On grant: pop that FIFO, load o_data[q], set o_valid[q]=1, and set rr_ptr[q] = winner+1 mod 5.
  - An input can win at most one output per cycle; only its head requests.
- Output stage:
  - o_data/o_valid hold stable while o_valid & !i_ready.
  - o_valid clears after i_ready when no new grant occurs.
  - Back-to-back delivery is at full rate: one flit per cycle per output when i_ready is held high.
- Latency: a flit accepted at edge N appears on o_data/o_valid after edge N+1 when uncontended and the output is free.
- Throughput: up to 5 flits per cycle through the node (disjoint outputs).
- Ordering: FIFO order per input is preserved. Flits from one input to one output are never reordered.
- Starvation-free: any persistently requesting input wins within 5 grants of its output.

Test Plan:
- Routing at node (4,4), single flit on t:
  - 0xAA0304 → o_data l = 0xAA0304 one cycle after accept.
  - 0xAA0404 → pe.
  - 0xAA0403 → b.
  - 0xAA0503 → r (X first).
  - 0xAA0405 → t.
- Backpressure: i_ready l=0, send 0x110304 on t. Hold 3 cycles → o_valid l=1 with stable data. Raise i_ready → handshake, o_valid drops next cycle.
- Contention: pe, r and b all send to l every cycle, i_ready l=1 → output order pe, r, b, pe, r, b…; no input waits >2 grants.
- FIFO full: DEPTH=4, i_ready pe=0, push 6 flits on t to pe.
  - 1 flit sits in the output stage and 4 are buffered; o_ready t=0 after the 5th accept.
  - Release → flits arrive in order. o_ready t reasserts one cycle after the first pop.
- Reset mid-operation: with 3 flits buffered, pull rstn low for 1 cycle → o_valid=0 and o_ready=0 immediately. No stale flits appear after release.
- Parallel traffic: t→b, b→t, l→r, r→l and pe→pe simultaneously → all 5 outputs valid in the same cycle, one flit per cycle each.
